// File: rtl/game_timer_chain.sv
// game_timer_chain: prescaled two-digit BCD game-length timer that drives the end-of-game RS flip-flop
module game_timer_chain #(
    parameter int         PRESCALE = 1_000_000,
    parameter logic [7:0] LIMIT    = 8'h45
) (
    input  logic       CLK_DRV,
    input  logic       RESET,
    input  logic       START,
    input  logic       PAUSE,
    output logic [7:0] COUNT,
    output logic       TICK,
    output logic       RUNNING,
    output logic       GAME_S,
    output logic       GAME_R
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [7:0]    count_n, inc;
    logic          tick_n, s_n, r_n, start_q, start_edge;

    assign start_edge = START & ~start_q;
    assign RUNNING    = state == RUN;

    // BCD increment of the elapsed count; each digit wraps 9 -> 0, ones carry into tens
    always_comb begin
        inc[3:0] = (COUNT[3:0] == 4'd9) ? 4'd0 : COUNT[3:0] + 4'd1;
        inc[7:4] = (COUNT[3:0] != 4'd9) ? COUNT[7:4] : (COUNT[7:4] == 4'd9) ? 4'd0 : COUNT[7:4] + 4'd1;
    end

    // next state and next registered outputs; GAME_S only ever falls on the edge that raises GAME_R
    always_comb begin
        state_n = state;
        pre_n   = pre;
        count_n = COUNT;
        tick_n  = 1'b0;
        s_n     = GAME_S;
        r_n     = 1'b0;
        if (state == RUN) begin
            if (!PAUSE) begin
                pre_n = (pre == PMAX) ? '0 : pre + 1'b1;
                if (pre == PMAX) begin
                    tick_n  = 1'b1;
                    count_n = inc;
                    if (inc == LIMIT) begin
                        state_n = DONE;
                        s_n     = 1'b1;
                    end
                end
            end
        end else if (start_edge) begin
            state_n = RUN;
            pre_n   = '0;
            count_n = 8'h00;
            r_n     = 1'b1;
            s_n     = 1'b0;
        end
    end

    // state and output registers; start_q resets high so a START held through reset is not an edge
    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            state   <= IDLE;
            pre     <= '0;
            COUNT   <= 8'h00;
            TICK    <= 1'b0;
            GAME_S  <= 1'b0;
            GAME_R  <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state   <= state_n;
            pre     <= pre_n;
            COUNT   <= count_n;
            TICK    <= tick_n;
            GAME_S  <= s_n;
            GAME_R  <= r_n;
            start_q <= START;
        end
    end
endmodule
